// File: rtl/interrupt_controller_if.sv
// Core-facing bus of the interrupt controller: the configuration register port
// plus the request / acknowledge / end-of-interrupt handshake.
interface interrupt_controller_if #(
  parameter int NUM_IRQ = 8
);
  localparam int ID_W = $clog2(NUM_IRQ);

  logic            cfg_we;
  logic [1:0]      cfg_addr;
  logic [31:0]     cfg_wdata;
  logic [31:0]     cfg_rdata;
  logic            int_ack;
  logic            int_eoi;
  logic            interrupt;
  logic [ID_W-1:0] int_id;
  logic [31:0]     int_vector;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, int_ack, int_eoi,
    input  cfg_rdata, interrupt, int_id, int_vector
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, int_ack, int_eoi,
    output cfg_rdata, interrupt, int_id, int_vector
  );
endinterface

// File: rtl/interrupt_controller.sv
// Prioritised, non-nesting interrupt controller: synchronises and latches request
// lines, masks and priority-encodes them, and hands one request at a time to the core.
module interrupt_controller #(
  parameter int          NUM_IRQ    = 8,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter int          VEC_STRIDE = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  interrupt_controller_if.slave bus
);
  localparam int ID_W = $clog2(NUM_IRQ);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_MASK    = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_MODE    = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  logic [NUM_IRQ-1:0] sync_s1, sync_s2, sync_s2d;
  logic [NUM_IRQ-1:0] mask, pending, mode;
  logic [NUM_IRQ-1:0] rise, eligible, w1c, ack_clr, clr;
  logic [ID_W-1:0]    id_q, id_d, winner;
  state_t             state, state_d;
  logic               ack_taken;
  logic               unused_wdata;

  assign rise      = sync_s2 & ~sync_s2d;
  assign eligible  = pending & mask;
  assign ack_taken = (state == REQ) && bus.int_ack;
  assign w1c       = (bus.cfg_we && bus.cfg_addr == ADDR_PENDING)
                     ? bus.cfg_wdata[NUM_IRQ-1:0] : '0;
  assign ack_clr   = ack_taken ? (NUM_IRQ'(1) << id_q) : '0;
  assign clr       = w1c | ack_clr;
  // Only the low NUM_IRQ bits of write data carry configuration.
  assign unused_wdata = ^bus.cfg_wdata;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_s1  <= '0;
      sync_s2  <= '0;
      sync_s2d <= '0;
    end else begin
      sync_s1  <= irq_in;
      sync_s2  <= sync_s1;
      sync_s2d <= sync_s2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask    <= '0;
      mode    <= '0;
      pending <= '0;
    end else begin
      if (bus.cfg_we && bus.cfg_addr == ADDR_MASK) mask <= bus.cfg_wdata[NUM_IRQ-1:0];
      if (bus.cfg_we && bus.cfg_addr == ADDR_MODE) mode <= bus.cfg_wdata[NUM_IRQ-1:0];
      // Level sources mirror the line; edge sources latch rises, and a rise beats a clear.
      pending <= (mode & sync_s2) | (~mode & ((pending & ~clr) | rise));
    end
  end

  // Fixed priority: the lowest-numbered eligible source wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      id_q  <= '0;
    end else begin
      state <= state_d;
      id_q  <= id_d;
    end
  end

  always_comb begin
    state_d = state;
    id_d    = id_q;
    unique case (state)
      IDLE: begin
        if (|eligible) begin
          state_d = REQ;
          id_d    = winner;
        end
      end
      REQ: begin
        // An ack in the same cycle as a withdrawal still takes the request.
        if (bus.int_ack) begin
          state_d = SERVICE;
        end else if (!eligible[id_q]) begin
          state_d = IDLE;
          id_d    = '0;
        end
      end
      SERVICE: begin
        if (bus.int_eoi) begin
          state_d = IDLE;
          id_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        id_d    = '0;
      end
    endcase
  end

  assign bus.interrupt  = (state == REQ);
  assign bus.int_id     = id_q;
  assign bus.int_vector = VEC_BASE + 32'(id_q) * 32'(VEC_STRIDE);

  always_comb begin
    bus.cfg_rdata = '0;
    unique case (bus.cfg_addr)
      ADDR_MASK:    bus.cfg_rdata[NUM_IRQ-1:0] = mask;
      ADDR_PENDING: bus.cfg_rdata[NUM_IRQ-1:0] = pending;
      ADDR_MODE:    bus.cfg_rdata[NUM_IRQ-1:0] = mode;
      ADDR_STATUS: begin
        bus.cfg_rdata[0]         = (state == REQ);
        bus.cfg_rdata[1]         = (state == SERVICE);
        bus.cfg_rdata[8 +: ID_W] = id_q;
      end
      default: bus.cfg_rdata = '0;
    endcase
  end
endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: latency, priority, masking, withdrawal,
// level-mode re-request and asynchronous reset, against hand-computed values.
module tb_interrupt_controller;
  localparam int NUM_IRQ = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [NUM_IRQ-1:0] irq_in = '0;
  int                 n_tests = 0;
  int                 n_fail = 0;

  interrupt_controller_if #(.NUM_IRQ(NUM_IRQ)) bus ();

  interrupt_controller #(
    .NUM_IRQ   (NUM_IRQ),
    .VEC_BASE  (32'h0000_0100),
    .VEC_STRIDE(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .irq_in(irq_in),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; return 1 ns after the last one.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = addr;
    bus.cfg_wdata = data;
    step();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    bus.cfg_addr = addr;
    #1;
    check(tag, bus.cfg_rdata, exp);
  endtask

  task automatic chk_req(input string tag, input logic irq, input logic [31:0] id,
                         input logic [31:0] vec);
    check({tag, "_irq"}, 32'(bus.interrupt), 32'(irq));
    check({tag, "_id"},  32'(bus.int_id), id);
    check({tag, "_vec"}, bus.int_vector, vec);
  endtask

  task automatic pulse_irq(input logic [NUM_IRQ-1:0] lines);
    irq_in = lines;
    step();
    irq_in = '0;
  endtask

  task automatic ack();
    bus.int_ack = 1'b1;
    step();
    bus.int_ack = 1'b0;
  endtask

  task automatic eoi();
    bus.int_eoi = 1'b1;
    step();
    bus.int_eoi = 1'b0;
  endtask

  initial begin
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = 2'd0;
    bus.cfg_wdata = '0;
    bus.int_ack   = 1'b0;
    bus.int_eoi   = 1'b0;
    #12;
    reset = 1'b1;
    step();

    // Reset state
    chk_req("rst", 1'b0, 0, 32'h100);
    chk_reg("rst_mask", 2'd0, 32'h0);
    chk_reg("rst_pend", 2'd1, 32'h0);
    chk_reg("rst_mode", 2'd2, 32'h0);
    chk_reg("rst_stat", 2'd3, 32'h0);

    // Single edge source: four-edge latency, ack, eoi
    wr(2'd0, 32'hFF);
    chk_reg("mask_rb", 2'd0, 32'hFF);
    pulse_irq(8'h08);                    // edge 1 samples the pulse
    check("lat_e1", 32'(bus.interrupt), 0);
    step(2);
    check("lat_e3", 32'(bus.interrupt), 0);
    chk_reg("lat_pend", 2'd1, 32'h08);
    step();
    chk_req("lat_e4", 1'b1, 3, 32'h10C);
    chk_reg("req_stat", 2'd3, 32'h301);
    ack();
    check("ack_irq", 32'(bus.interrupt), 0);
    chk_reg("ack_pend", 2'd1, 32'h0);
    chk_reg("ack_stat", 2'd3, 32'h302);
    eoi();
    chk_reg("eoi_stat", 2'd3, 32'h0);

    // Simultaneous sources: lower index first
    pulse_irq(8'h24);
    step(3);
    chk_req("pri_first", 1'b1, 2, 32'h108);
    ack();
    chk_reg("pri_pend", 2'd1, 32'h20);
    eoi();
    step();
    chk_req("pri_second", 1'b1, 5, 32'h114);
    ack();
    eoi();

    // Masked source stays pending, raises once unmasked
    wr(2'd0, 32'h00);
    pulse_irq(8'h02);
    step(5);
    chk_reg("msk_pend", 2'd1, 32'h02);
    check("msk_noirq", 32'(bus.interrupt), 0);
    wr(2'd0, 32'h02);
    check("unmsk_e0", 32'(bus.interrupt), 0);
    step();
    chk_req("unmsk_e1", 1'b1, 1, 32'h104);
    ack();
    eoi();

    // Withdrawal by W1C, then W1C coinciding with ack
    wr(2'd0, 32'hFF);
    pulse_irq(8'h10);
    step(3);
    chk_req("wd_req", 1'b1, 4, 32'h110);
    wr(2'd1, 32'h10);
    chk_reg("wd_pend", 2'd1, 32'h0);
    step();
    check("wd_irq", 32'(bus.interrupt), 0);
    chk_reg("wd_stat", 2'd3, 32'h0);
    pulse_irq(8'h10);
    step(3);
    chk_req("wdack_req", 1'b1, 4, 32'h110);
    bus.int_ack = 1'b1;
    wr(2'd1, 32'h10);
    bus.int_ack = 1'b0;
    chk_reg("wdack_stat", 2'd3, 32'h402);
    check("wdack_irq", 32'(bus.interrupt), 0);
    eoi();

    // Level-mode source held high re-requests after EOI
    wr(2'd2, 32'h01);
    irq_in = 8'h01;
    step(4);
    chk_req("lvl_req", 1'b1, 0, 32'h100);
    ack();
    chk_reg("lvl_pend", 2'd1, 32'h01);
    chk_reg("lvl_stat", 2'd3, 32'h002);
    eoi();
    check("lvl_eoi", 32'(bus.interrupt), 0);
    step();
    check("lvl_rereq", 32'(bus.interrupt), 1);
    ack();
    irq_in = 8'h00;
    step(4);
    chk_reg("lvl_drop_pend", 2'd1, 32'h0);
    eoi();
    step(3);
    check("lvl_quiet", 32'(bus.interrupt), 0);
    chk_reg("lvl_quiet_stat", 2'd3, 32'h0);

    // Asynchronous reset while in SERVICE
    wr(2'd2, 32'h00);
    pulse_irq(8'h40);
    step(3);
    ack();
    chk_reg("svc_stat", 2'd3, 32'h602);
    #1;
    reset = 1'b0;
    #1;
    chk_req("arst", 1'b0, 0, 32'h100);
    chk_reg("arst_mask", 2'd0, 32'h0);
    chk_reg("arst_stat", 2'd3, 32'h0);
    #1;
    reset = 1'b1;
    step();
    eoi();
    chk_reg("post_eoi_stat", 2'd3, 32'h0);
    check("post_eoi_irq", 32'(bus.interrupt), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
